ahbl_dma_master: RTL and testbench

//  - Single-channel word-copy DMA. It is an AHB-Lite initiator that issues transfers to the existing AHB-Lite responders (ahbl_ram, ahbl_gpio, ahbl_rom).
//  - Copies LEN 32-bit words from SRC to DST using one read data phase, then one write data phase, per word. There is no burst and no overlap.
//  - Configured by a sideband start/length handshake, driven by the CPU through a GPIO or register block. It sits as a second master ahead of the splitter.

---
 rtl/ahbl_pkg.sv | 17 +
 rtl/ahbl_dma_master.sv | 130 +++++++++++++
 tb/tb_ahbl_dma_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the DMA master state type.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_A,
        WR_D,
        DONE
    } dma_state_t;

endpackage

// File: rtl/ahbl_dma_master.sv
// Single-channel word-copy DMA acting as an AHB-Lite initiator: one read then one write per word.
// Optional sticky completion interrupt is built when DMA_IRQ_EN is defined.
module ahbl_dma_master
    import ahbl_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA,
    output logic             irq,
    input  logic             irq_clr
);

    dma_state_t       state, state_nxt;
    logic [31:0]      src_q, dst_q, buf_q;
    logic [LEN_W-1:0] len_q;
    logic             abort_q;
    logic             last_word;
    logic [3:0]       unused_addr_lsbs;

    assign unused_addr_lsbs = {src_addr[1:0], dst_addr[1:0]};
    assign last_word        = (words_done + LEN_W'(1)) == len_q;
    assign busy             = (state != IDLE);
    assign done             = (state == DONE);
    assign HSIZE            = HSIZE_WORD;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        HTRANS    = HTRANS_IDLE;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HWDATA    = '0;
        case (state)
            IDLE: if (start) state_nxt = (len == '0) ? DONE : RD_A;
            RD_A: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = src_q;
                if (HREADY) state_nxt = RD_D;
            end
            RD_D: if (HREADY) state_nxt = WR_A;
            WR_A: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = dst_q;
                HWRITE = 1'b1;
                if (HREADY) state_nxt = WR_D;
            end
            WR_D: begin
                HWDATA = buf_q;
                if (HREADY) state_nxt = (last_word || abort || abort_q) ? DONE : RD_A;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A short abort pulse seen mid-word is remembered until that word's write completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            src_q      <= '0;
            dst_q      <= '0;
            buf_q      <= '0;
            len_q      <= '0;
            words_done <= '0;
            aborted    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_q      <= {src_addr[31:2], 2'b00};
                    dst_q      <= {dst_addr[31:2], 2'b00};
                    len_q      <= len;
                    words_done <= '0;
                    aborted    <= 1'b0;
                    abort_q    <= 1'b0;
                end
                RD_A, WR_A: if (abort) abort_q <= 1'b1;
                RD_D: begin
                    if (abort)  abort_q <= 1'b1;
                    if (HREADY) buf_q   <= HRDATA;
                end
                WR_D: begin
                    if (HREADY) begin
                        words_done <= words_done + LEN_W'(1);
                        src_q      <= src_q + 32'd4;
                        dst_q      <= dst_q + 32'd4;
                        aborted    <= (abort || abort_q) && !last_word;
                    end else if (abort) begin
                        abort_q <= 1'b1;
                    end
                end
                DONE:    abort_q <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef DMA_IRQ_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)       irq <= 1'b0;
        else if (done)    irq <= 1'b1;
        else if (irq_clr) irq <= 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Directed bench for ahbl_dma_master: AHB-Lite RAM responder, per-cycle timeline model, literal spot checks.
module tb_ahbl_dma_master;

    logic        HCLK, HRESET, start, abort, irq_clr;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, aborted, irq;
    logic [15:0] words_done;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE, HREADY;

    ahbl_dma_master #(.LEN_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .irq(irq), .irq_clr(irq_clr)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    // ---------------- AHB-Lite RAM responder ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    int          wait_n = 0;
    bit          dp_active = 0, dp_write = 0;
    logic [31:0] dp_addr;
    int          wait_left = 0;

    always @(negedge HCLK) begin
        if (HRESET) begin
            dp_active = 0;
            HREADY    = 1'b1;
        end else begin
            HREADY = 1'b1;
            if (dp_active) begin
                if (wait_left > 0) begin
                    HREADY = 1'b0;
                    wait_left--;
                end else begin
                    if (dp_write) begin
                        mem[dp_addr] = HWDATA;
                        wr_log.push_back(dp_addr);
                    end else begin
                        HRDATA = mem.exists(dp_addr) ? mem[dp_addr] : init_word(dp_addr);
                    end
                    dp_active = 0;
                end
            end
            if (HREADY && HTRANS == 2'b10) begin
                dp_active = 1;
                dp_write  = HWRITE;
                dp_addr   = HADDR;
                wait_left = wait_n;
                if (!HWRITE) rd_log.push_back(HADDR);
            end
        end
    end

    // ---------------- timeline model + compare ----------------
    bit          chk_en = 0, m_active = 0, m_abort = 0;
    int          m_k = 0, m_n = 0, m_prev_n = 0, m_c = 4;
    logic [31:0] m_src, m_dst;
    int          cd, cw, co, clast;

    always @(negedge HCLK) begin
        if (chk_en && !HRESET) begin
            cd    = cyc - m_k;
            clast = m_n * m_c + 1;
            if (m_active && cd >= 1 && cd < clast) begin
                cw = (cd - 1) / m_c;
                co = (cd - 1) % m_c;
                chk("busy", busy, 1);
                chk("done", done, 0);
                chk("words_done", words_done, cw);
                if (co == 0) begin
                    chk("htrans_rd", HTRANS, 2'b10);
                    chk("haddr_rd", HADDR, m_src + 32'(4 * cw));
                    chk("hwrite_rd", HWRITE, 0);
                end else if (co == 2 + wait_n) begin
                    chk("htrans_wr", HTRANS, 2'b10);
                    chk("haddr_wr", HADDR, m_dst + 32'(4 * cw));
                    chk("hwrite_wr", HWRITE, 1);
                end else begin
                    chk("htrans_data", HTRANS, 2'b00);
                end
                if (co >= 3 + wait_n)
                    chk("hwdata", HWDATA, init_word(m_src + 32'(4 * cw)));
            end else if (m_active && cd == clast) begin
                chk("busy_done", busy, 1);
                chk("done_pulse", done, 1);
                chk("htrans_done", HTRANS, 2'b00);
                chk("words_done_end", words_done, m_n);
                chk("aborted", aborted, m_abort);
            end else begin
                chk("busy_idle", busy, 0);
                chk("done_idle", done, 0);
                chk("htrans_idle", HTRANS, 2'b00);
                chk("words_done_idle", words_done, (m_active && cd < 1) ? m_prev_n : m_n);
            end
            chk("hsize", HSIZE, 3'b010);
`ifndef DMA_IRQ_EN
            chk("irq_tied", irq, 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_job(input logic [31:0] s, input logic [31:0] dd, input int l,
                           input int ab_at, input int rs_at, input int clr_at,
                           input int exp_n, input bit exp_ab, output int lat);
        int  k;
        int  d;
        bit  got;
        @(posedge HCLK); #1;
        src_addr = s; dst_addr = dd; len = l[15:0]; start = 1'b1;
        k        = cyc;
        m_prev_n = m_n;
        m_n      = exp_n;
        m_c      = 4 + 2 * wait_n;
        m_src    = {s[31:2], 2'b00};
        m_dst    = {dd[31:2], 2'b00};
        m_abort  = exp_ab;
        m_k      = k;
        m_active = 1;
        got      = 0;
        lat      = -1;
        for (int t = 0; t < 400; t++) begin
            @(posedge HCLK); #1;
            d       = cyc - k;
            start   = (d == rs_at);
            abort   = (d == ab_at);
            irq_clr = (d == clr_at);
            if (d == 2 || d == rs_at) begin
                src_addr = 32'hDEAD_BEEF; dst_addr = 32'h1234_5677; len = 16'd7;
            end
            @(negedge HCLK);
            if (done) begin
                got = 1;
                lat = cyc - k;
                break;
            end
        end
        start = 1'b0; abort = 1'b0; irq_clr = 1'b0;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        chk("done_latency_model", lat, 1 + exp_n * m_c);
    endtask

    int lat;
    int r0, w0;

    initial begin
        HRESET = 1'b1; start = 0; abort = 0; irq_clr = 0;
        src_addr = '0; dst_addr = '0; len = '0; HREADY = 1'b1; HRDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_words_done", words_done, 0);
        chk("rst_htrans", HTRANS, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_hsize", HSIZE, 3'b010);
        chk("rst_irq", irq, 0);
        HRESET = 1'b0;
        chk_en = 1;

        // T1: zero-wait copy of 4 words
        r0 = rd_log.size(); w0 = wr_log.size();
        run_job(32'h2000_0000, 32'h2000_0100, 4, -1, -1, -1, 4, 0, lat);
        chk("t1_latency", lat, 17);
        chk("t1_words_done", words_done, 4);
        chk("t1_reads", rd_log.size() - r0, 4);
        chk("t1_writes", wr_log.size() - w0, 4);
        chk("t1_mem0_literal", mem[32'h2000_0100], 32'hE3C3_0000);
        for (int i = 0; i < 4; i++)
            chk("t1_mem", mem[32'h2000_0100 + 32'(4 * i)], init_word(32'h2000_0000 + 32'(4 * i)));
`ifdef DMA_IRQ_EN
        @(posedge HCLK); #1;
        chk("t1_irq_set", irq, 1);
        irq_clr = 1'b1;
        @(posedge HCLK); #1;
        irq_clr = 1'b0;
        chk("t1_irq_clr", irq, 0);
`endif

        // T2: two wait states in every data phase
        wait_n = 2;
        run_job(32'h2000_0000, 32'h2000_0200, 4, -1, -1, -1, 4, 0, lat);
        chk("t2_latency", lat, 33);
        for (int i = 0; i < 4; i++)
            chk("t2_mem", mem[32'h2000_0200 + 32'(4 * i)], init_word(32'h2000_0000 + 32'(4 * i)));
        wait_n = 0;

        // T3: zero-length job
        r0 = rd_log.size(); w0 = wr_log.size();
        run_job(32'h2000_0000, 32'h2000_0400, 0, -1, -1, -1, 0, 0, lat);
        chk("t3_latency", lat, 1);
        chk("t3_words_done", words_done, 0);
        chk("t3_no_bus", (rd_log.size() - r0) + (wr_log.size() - w0), 0);

        // T4: abort during word-3 read data phase, plus an ignored restart
        w0 = wr_log.size();
        run_job(32'h2000_1000, 32'h2000_1100, 8, 10, 5, -1, 3, 1, lat);
        chk("t4_latency", lat, 13);
        chk("t4_words_done", words_done, 3);
        chk("t4_aborted", aborted, 1);
        chk("t4_writes", wr_log.size() - w0, 3);

        // T5: source wraps past 2^32, unaligned destination
        r0 = rd_log.size(); w0 = wr_log.size();
        run_job(32'hFFFF_FFF8, 32'h3000_0003, 3, -1, -1, -1, 3, 0, lat);
        chk("t5_rd0", rd_log[r0],     32'hFFFF_FFF8);
        chk("t5_rd1", rd_log[r0 + 1], 32'hFFFF_FFFC);
        chk("t5_rd2", rd_log[r0 + 2], 32'h0000_0000);
        chk("t5_wr0", wr_log[w0],     32'h3000_0000);
        chk("t5_wr2", wr_log[w0 + 2], 32'h3000_0008);
        chk("t5_aborted", aborted, 0);

        // T6: reset asserted in the write data phase of word 2
        chk_en = 0;
        @(posedge HCLK); #1;
        src_addr = 32'h2000_0000; dst_addr = 32'h2000_0300; len = 16'd4; start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        repeat (7) @(posedge HCLK);
        #1;
        chk("t6_in_wr_d", HWDATA, 32'hE3C3_0004);
        chk("t6_busy_before", busy, 1);
        HRESET = 1'b1;
        #1;
        chk("t6_htrans", HTRANS, 0);
        chk("t6_busy", busy, 0);
        chk("t6_haddr", HADDR, 0);
        chk("t6_words_done", words_done, 0);
        chk("t6_irq", irq, 0);
        @(posedge HCLK); #1;
        HRESET   = 1'b0;
        m_active = 0; m_n = 0; m_prev_n = 0; m_abort = 0;
        chk_en   = 1;

        // irq_clr coinciding with done: set must win
        run_job(32'h2000_2000, 32'h2000_2100, 1, -1, -1, 5, 1, 0, lat);
        @(posedge HCLK); #1;
`ifdef DMA_IRQ_EN
        chk("t6_irq_set_wins", irq, 1);
        irq_clr = 1'b1;
        @(posedge HCLK); #1;
        irq_clr = 1'b0;
        chk("t6_irq_later_clr", irq, 0);
`else
        chk("t6_irq_off", irq, 0);
`endif
        repeat (3) @(posedge HCLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
